// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-requester ALU session arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int OP_W    = 2;
    localparam int DATA_W  = 32;
    localparam int FLAGS_W = 5;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of both requester ALU ports and the shared ALU port; master = requesters/ALU side, slave = arbiter.
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic               i_r0_req,          i_r1_req;
    logic               o_r0_gnt,          o_r1_gnt;
    logic [OP_W-1:0]    i_r0_input_op,     i_r1_input_op;
    logic               i_r0_data_valid,   i_r1_data_valid;
    logic [DATA_W-1:0]  i_r0_data,         i_r1_data;
    logic [OP_W-1:0]    i_r0_output_op,    i_r1_output_op;
    logic               i_r0_result_empty, i_r1_result_empty;
    logic               o_r0_result_valid, o_r1_result_valid;
    logic [DATA_W-1:0]  o_r0_result,       o_r1_result;
    logic [FLAGS_W-1:0] o_r0_result_flags, o_r1_result_flags;

    logic [OP_W-1:0]    o_alu_input_op;
    logic               o_alu_data_valid;
    logic [DATA_W-1:0]  o_alu_data;
    logic [OP_W-1:0]    o_alu_output_op;
    logic               o_alu_result_empty;
    logic               i_alu_result_valid;
    logic [DATA_W-1:0]  i_alu_result;
    logic [FLAGS_W-1:0] i_alu_result_flags;

    logic               o_timeout;

    modport master (
        output i_r0_req, i_r0_input_op, i_r0_data_valid, i_r0_data, i_r0_output_op, i_r0_result_empty,
        output i_r1_req, i_r1_input_op, i_r1_data_valid, i_r1_data, i_r1_output_op, i_r1_result_empty,
        input  o_r0_gnt, o_r0_result_valid, o_r0_result, o_r0_result_flags,
        input  o_r1_gnt, o_r1_result_valid, o_r1_result, o_r1_result_flags,
        input  o_alu_input_op, o_alu_data_valid, o_alu_data, o_alu_output_op, o_alu_result_empty,
        output i_alu_result_valid, i_alu_result, i_alu_result_flags,
        input  o_timeout
    );

    modport slave (
        input  i_r0_req, i_r0_input_op, i_r0_data_valid, i_r0_data, i_r0_output_op, i_r0_result_empty,
        input  i_r1_req, i_r1_input_op, i_r1_data_valid, i_r1_data, i_r1_output_op, i_r1_result_empty,
        output o_r0_gnt, o_r0_result_valid, o_r0_result, o_r0_result_flags,
        output o_r1_gnt, o_r1_result_valid, o_r1_result, o_r1_result_flags,
        output o_alu_input_op, o_alu_data_valid, o_alu_data, o_alu_output_op, o_alu_result_empty,
        input  i_alu_result_valid, i_alu_result, i_alu_result_flags,
        output o_timeout
    );

endinterface

// File: rtl/alu_arb_watchdog.sv
// Session watchdog: down-counts contended OWN cycles, revokes at terminal count and locks out the revoked owner.
module alu_arb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       own0,
    input  logic       own1,
    input  logic       r0_req,
    input  logic       r1_req,
    input  logic       r0_req_eff,
    input  logic       r1_req_eff,
    output logic       expire,
    output logic [1:0] lock,
    output logic       o_timeout
);

    logic [TW-1:0] cnt;
    logic          contended;

    // A locked-out requester is not really waiting, so it does not count against the owner.
    assign contended = (own0 & r1_req_eff) | (own1 & r0_req_eff);
    assign expire    = contended && (cnt <= TW'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= TW'(TIMEOUT);
            lock      <= 2'b00;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= expire;
            if (!(own0 | own1))
                cnt <= TW'(TIMEOUT);
            else if (contended && !expire)
                cnt <= cnt - TW'(1);
            lock[0] <= (expire & own0) | (lock[0] & r0_req);
            lock[1] <= (expire & own1) | (lock[1] & r1_req);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Session-based round-robin arbiter sharing one ALU between two requesters.
// Optional session timeout/lockout enabled by defining ALU_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no owner, arbitrate requests
//   OWN0  | requester 0 drives the ALU
//   OWN1  | requester 1 drives the ALU
//   GAP   | one dead cycle after a release, arbitrates for next edge
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input logic         i_clk,
    input logic         i_rst_n,
    alu_arbiter_if.slave bus
);

    arb_state_e state;
    logic       last_owner;
    logic       gnt0, gnt1;
    logic       expire;
    logic [1:0] lock;
    logic       req0_eff, req1_eff;

    assign req0_eff = bus.i_r0_req & ~lock[0];
    assign req1_eff = bus.i_r1_req & ~lock[1];

`ifdef ALU_ARB_TIMEOUT_EN
    logic own0, own1;
    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

    alu_arb_watchdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_watchdog (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .own0       (own0),
        .own1       (own1),
        .r0_req     (bus.i_r0_req),
        .r1_req     (bus.i_r1_req),
        .r0_req_eff (req0_eff),
        .r1_req_eff (req1_eff),
        .expire     (expire),
        .lock       (lock),
        .o_timeout  (bus.o_timeout)
    );
`else
    assign expire        = 1'b0;
    assign lock          = 2'b00;
    assign bus.o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_owner <= REQ1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (req0_eff && (!req1_eff || last_owner == REQ1)) begin
                        state <= OWN0;
                        gnt0  <= 1'b1;
                    end else if (req1_eff) begin
                        state <= OWN1;
                        gnt1  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN0: begin
                    if (!bus.i_r0_req || expire) begin
                        state      <= GAP;
                        gnt0       <= 1'b0;
                        last_owner <= REQ0;
                    end
                end
                OWN1: begin
                    if (!bus.i_r1_req || expire) begin
                        state      <= GAP;
                        gnt1       <= 1'b0;
                        last_owner <= REQ1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_r0_gnt = gnt0;
    assign bus.o_r1_gnt = gnt1;

    // Everything toward the ALU and back is gated by the registered owner so no stray push/pop leaks.
    always_comb begin
        bus.o_alu_input_op     = '0;
        bus.o_alu_data_valid   = 1'b0;
        bus.o_alu_data         = '0;
        bus.o_alu_output_op    = '0;
        bus.o_alu_result_empty = 1'b0;
        bus.o_r0_result_valid  = 1'b0;
        bus.o_r0_result        = '0;
        bus.o_r0_result_flags  = '0;
        bus.o_r1_result_valid  = 1'b0;
        bus.o_r1_result        = '0;
        bus.o_r1_result_flags  = '0;
        case (state)
            OWN0: begin
                bus.o_alu_input_op     = bus.i_r0_input_op;
                bus.o_alu_data_valid   = bus.i_r0_data_valid;
                bus.o_alu_data         = bus.i_r0_data;
                bus.o_alu_output_op    = bus.i_r0_output_op;
                bus.o_alu_result_empty = bus.i_r0_result_empty;
                bus.o_r0_result_valid  = bus.i_alu_result_valid;
                bus.o_r0_result        = bus.i_alu_result;
                bus.o_r0_result_flags  = bus.i_alu_result_flags;
            end
            OWN1: begin
                bus.o_alu_input_op     = bus.i_r1_input_op;
                bus.o_alu_data_valid   = bus.i_r1_data_valid;
                bus.o_alu_data         = bus.i_r1_data;
                bus.o_alu_output_op    = bus.i_r1_output_op;
                bus.o_alu_result_empty = bus.i_r1_result_empty;
                bus.o_r1_result_valid  = bus.i_alu_result_valid;
                bus.o_r1_result        = bus.i_alu_result;
                bus.o_r1_result_flags  = bus.i_alu_result_flags;
            end
            default: begin
            end
        endcase
    end

endmodule
